rvm_mem_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch requester (i_*) and the load/store requester (d_*) of the multi-cycle RISC-V core. Sits between rvm_control-sequenced datapath ports and the external memory bus.
- Exactly one transaction outstanding at a time.
- Round-robin arbitration on conflicts.
- Routes each response back to the requester that owns the transaction.
- Bounds stalled transactions with a timeout that returns an error.

---
 rtl/rvm_mem_arbiter_pkg.sv | 21 ++
 rtl/rvm_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_rvm_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rvm_mem_arbiter_pkg.sv
// Shared encodings and the arbitration rule for the fetch/load-store memory arbiter.
package rvm_mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Returns {win, owner}; on a tie the requester that was not served last wins.
  function automatic logic [1:0] arb_pick(input logic i_req, input logic d_req,
                                          input logic last_owner);
    if (i_req && d_req) return {1'b1, ~last_owner};
    else if (d_req)     return {1'b1, OWN_D};
    else if (i_req)     return {1'b1, OWN_I};
    else                return {1'b0, OWN_I};
  endfunction

endpackage

// File: rtl/rvm_mem_arbiter.sv
// Single-outstanding round-robin arbiter between instruction fetch and load/store
// for one shared memory port, with a response timeout that reports an error.
module rvm_mem_arbiter
  import rvm_mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ack,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_error,
  input  logic              d_req,
  input  logic [XLEN-1:0]   d_addr,
  input  logic              d_wen,
  input  logic [XLEN/8-1:0] d_strb,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_ack,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_error,
  output logic              m_req,
  output logic [XLEN-1:0]   m_addr,
  output logic              m_wen,
  output logic [XLEN/8-1:0] m_strb,
  output logic [XLEN-1:0]   m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  input  logic              m_error
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic             owner;
  logic             last_owner;
  logic [CNT_W-1:0] cnt;
  logic             win;
  logic             pick;
  logic             expired;
  logic             finish;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_err;

  assign m_req = (state == ST_REQ);
  assign i_ack = (state == ST_DONE) && (owner == OWN_I);
  assign d_ack = (state == ST_DONE) && (owner == OWN_D);

  // A response arriving in the same cycle the timeout expires takes priority.
  always_comb begin
    {win, pick} = arb_pick(i_req, d_req, last_owner);
    expired     = (TIMEOUT > 0) && (cnt >= CNT_LAST);
    finish      = 1'b0;
    rsp_data    = '0;
    rsp_err     = 1'b1;
    if (state == ST_REQ) begin
      finish = !m_gnt && expired;
    end else if (state == ST_RSP) begin
      finish = m_rvalid || expired;
      if (m_rvalid) begin
        rsp_data = m_rdata;
        rsp_err  = m_error;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      cnt        <= '0;
      m_addr     <= '0;
      m_wen      <= 1'b0;
      m_strb     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      i_error    <= 1'b0;
      d_rdata    <= '0;
      d_error    <= 1'b0;
    end else begin
      if ((state == ST_REQ || state == ST_RSP) && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (win) begin
            owner      <= pick;
            last_owner <= pick;
            cnt        <= '0;
            m_addr     <= (pick == OWN_D) ? d_addr : i_addr;
            m_wen      <= (pick == OWN_D) && d_wen;
            m_strb     <= (pick == OWN_D) ? d_strb : '0;
            m_wdata    <= (pick == OWN_D) ? d_wdata : '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_gnt)       state <= ST_RSP;
          else if (finish) state <= ST_DONE;
        end
        ST_RSP: begin
          if (finish) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Only the owner's response registers change, so the other side keeps its last result.
      if (finish) begin
        if (owner == OWN_D) begin
          d_rdata <= rsp_data;
          d_error <= rsp_err;
        end else begin
          i_rdata <= rsp_data;
          i_error <= rsp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Bench for rvm_mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory, all compared each cycle against a transaction model.
module tb_rvm_mem_arbiter;
  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_wen = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0] d_strb = '0;
  logic m_gnt = 1'b0, m_rvalid = 1'b0, m_error = 1'b0;
  logic [31:0] m_rdata = '0;
  logic i_ack, i_error, d_ack, d_error, m_req, m_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_strb;

  rvm_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_error(i_error),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_error(d_error),
    .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_error(m_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model: a pending transaction is either waiting for its grant
  // or waiting for its data; the ack cycle follows completion or expiry.
  bit          mb_busy = 0, mb_granted = 0, mb_ack = 0, mb_own = 0, mb_last = 0;
  int          mb_age = 0;
  logic [31:0] mb_addr = '0, mb_wdata = '0, mb_i_rd = '0, mb_d_rd = '0;
  logic [3:0]  mb_strb = '0;
  bit          mb_wen = 0, mb_i_er = 0, mb_d_er = 0;

  logic        sn_rstn, sn_ireq, sn_dreq, sn_dwen, sn_gnt, sn_rvalid, sn_err;
  logic [31:0] sn_iaddr, sn_daddr, sn_dwdata, sn_rdata;
  logic [3:0]  sn_dstrb;

  always @(posedge clk) begin
    bit fin, expired;
    logic [31:0] rd;
    bit er;
    sn_rstn = resetn; sn_ireq = i_req; sn_dreq = d_req; sn_dwen = d_wen;
    sn_gnt = m_gnt; sn_rvalid = m_rvalid; sn_err = m_error; sn_rdata = m_rdata;
    sn_iaddr = i_addr; sn_daddr = d_addr; sn_dwdata = d_wdata; sn_dstrb = d_strb;
    #1;
    cyc++;
    fin = 0; rd = '0; er = 0;
    if (!sn_rstn) begin
      mb_busy = 0; mb_granted = 0; mb_ack = 0; mb_own = 0; mb_last = 0; mb_age = 0;
      mb_addr = '0; mb_wdata = '0; mb_strb = '0; mb_wen = 0;
      mb_i_rd = '0; mb_d_rd = '0; mb_i_er = 0; mb_d_er = 0;
    end else if (mb_ack) begin
      mb_ack = 0;
    end else if (!mb_busy) begin
      if (sn_ireq || sn_dreq) begin
        if (sn_ireq && sn_dreq) mb_own = !mb_last;
        else                    mb_own = sn_dreq;
        mb_last = mb_own; mb_busy = 1; mb_granted = 0; mb_age = 0;
        if (mb_own) begin
          mb_addr = sn_daddr; mb_wen = sn_dwen; mb_strb = sn_dstrb; mb_wdata = sn_dwdata;
        end else begin
          mb_addr = sn_iaddr; mb_wen = 0; mb_strb = '0; mb_wdata = '0;
        end
      end
    end else begin
      expired = (mb_age >= TMO - 1);
      if (!mb_granted) begin
        if (sn_gnt) mb_granted = 1;
        else if (expired) begin fin = 1; rd = '0; er = 1; end
      end else begin
        if (sn_rvalid) begin fin = 1; rd = sn_rdata; er = sn_err; end
        else if (expired) begin fin = 1; rd = '0; er = 1; end
      end
      mb_age++;
      if (fin) begin
        mb_busy = 0; mb_ack = 1;
        if (mb_own) begin mb_d_rd = rd; mb_d_er = er; end
        else        begin mb_i_rd = rd; mb_i_er = er; end
      end
    end
    check("m_req",   m_req,   mb_busy && !mb_granted);
    check("m_addr",  m_addr,  mb_addr);
    check("m_wen",   m_wen,   mb_wen);
    check("m_strb",  m_strb,  mb_strb);
    check("m_wdata", m_wdata, mb_wdata);
    check("i_ack",   i_ack,   mb_ack && !mb_own);
    check("d_ack",   d_ack,   mb_ack && mb_own);
    check("i_rdata", i_rdata, mb_i_rd);
    check("i_error", i_error, mb_i_er);
    check("d_rdata", d_rdata, mb_d_rd);
    check("d_error", d_error, mb_d_er);
    check("ack_excl", i_ack & d_ack, 0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    i_req = 0; d_req = 0; d_wen = 0; d_strb = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0; m_error = 0;
  endtask

  task automatic do_reset();
    quiet(); resetn = 0; tick(); tick(); resetn = 1;
  endtask

  // Called in a REQ cycle: grant now, respond in the next cycle; returns in the ack cycle.
  task automatic serve_now(input logic [31:0] rd, input bit er);
    m_gnt = 1; tick();
    m_gnt = 0; m_rvalid = 1; m_rdata = rd; m_error = er; tick();
    m_rvalid = 0; m_error = 0;
  endtask

  initial begin
    bit acc;
    int rsp_in;
    int prev_ack;
    do_reset();
    check("rst_mreq", m_req, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_maddr", m_addr, 0);

    // fetch only, minimum latency
    i_req = 1; i_addr = 32'h100; tick();
    check("t1_mreq", m_req, 1); check("t1_maddr", m_addr, 32'h100); check("t1_mwen", m_wen, 0);
    m_gnt = 1; tick();
    check("t1_mreq_rsp", m_req, 0);
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; tick();
    check("t1_iack", i_ack, 1); check("t1_irdata", i_rdata, 32'hDEADBEEF); check("t1_dack", d_ack, 0);
    m_rvalid = 0; i_req = 0; tick();
    check("t1_iack_low", i_ack, 0);

    // simultaneous requests after reset: d first, then i wins the next tie
    do_reset();
    d_req = 1; d_addr = 32'h200; d_wen = 1; d_strb = 4'hF; d_wdata = 32'h12345678;
    i_req = 1; i_addr = 32'h300; tick();
    check("t2_mwen", m_wen, 1); check("t2_maddr", m_addr, 32'h200);
    check("t2_mwdata", m_wdata, 32'h12345678); check("t2_mstrb", m_strb, 4'hF);
    serve_now(32'h0, 0);
    check("t2_dack", d_ack, 1); check("t2_iack0", i_ack, 0);
    d_req = 0; tick();
    d_req = 1; d_addr = 32'h204; d_wen = 0; d_strb = 4'h3; tick();
    check("t2_tie_i", m_addr, 32'h300); check("t2_i_wen", m_wen, 0); check("t2_i_strb", m_strb, 0);
    serve_now(32'hCAFE0001, 0);
    check("t2_iack", i_ack, 1); check("t2_irdata", i_rdata, 32'hCAFE0001);
    i_req = 0; tick(); tick();
    check("t2_d_again", m_addr, 32'h204);
    serve_now(32'h0BAD0002, 0);
    check("t2_dack2", d_ack, 1); check("t2_drdata", d_rdata, 32'h0BAD0002);
    d_req = 0; tick();

    // stalled grant hits the timeout
    i_req = 1; i_addr = 32'h400; tick();
    for (int k = 0; k < 4; k++) begin
      check("t3_mreq_held", m_req, 1);
      tick();
    end
    check("t3_mreq_drop", m_req, 0); check("t3_iack", i_ack, 1);
    check("t3_ierror", i_error, 1); check("t3_irdata", i_rdata, 0);
    i_req = 0; m_rvalid = 1; m_rdata = 32'h55; tick(); tick();
    m_rvalid = 0;
    check("t3_late_noack", {i_ack, d_ack}, 0); check("t3_irdata_kept", i_rdata, 0);

    // bus error on a load, then a clean load
    d_req = 1; d_addr = 32'h500; d_wen = 0; d_strb = '0; tick();
    serve_now(32'h77, 1);
    check("t4_dack", d_ack, 1); check("t4_derror", d_error, 1);
    d_req = 0; tick();
    d_req = 1; d_addr = 32'h504; tick();
    serve_now(32'h88, 0);
    check("t4_derror_clr", d_error, 0); check("t4_drdata", d_rdata, 32'h88);
    d_req = 0; tick();

    // reset while waiting for the response
    i_req = 1; i_addr = 32'h600; tick();
    m_gnt = 1; tick();
    m_gnt = 0; resetn = 0; i_req = 0; tick();
    check("t5_mreq", m_req, 0); check("t5_maddr", m_addr, 0);
    check("t5_ierror", i_error, 0); check("t5_drdata", d_rdata, 0);
    resetn = 1; m_rvalid = 1; m_rdata = 32'h99; tick();
    m_rvalid = 0; tick();
    check("t5_noack", {i_ack, d_ack}, 0); check("t5_irdata", i_rdata, 0);

    // back-to-back fetches at earliest cycles
    prev_ack = 0;
    i_req = 1; i_addr = 32'h1000;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t6_mreq", m_req, 1);
      serve_now(32'hA000 + n, 0);
      check("t6_iack", i_ack, 1); check("t6_mreq_done", m_req, 0);
      if (n > 0) check("t6_period", cyc - prev_ack, 4);
      prev_ack = cyc;
      i_req = 0; tick();
      i_req = 1; i_addr = i_addr + 4;
    end
    i_req = 0; tick(); tick();

    // randomized requesters and memory
    acc = 0; rsp_in = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!resetn) resetn = 1;
      m_rvalid = 0; m_error = 0;
      if (acc) begin rsp_in = int'($urandom_range(0, 3)); acc = 0; end
      if (rsp_in == 0) begin
        m_rvalid = 1; m_rdata = $urandom; m_error = ($urandom_range(0, 7) == 0); rsp_in = -1;
      end else if (rsp_in > 0) begin
        rsp_in--;
      end else if ($urandom_range(0, 19) == 0) begin
        m_rvalid = 1; m_rdata = $urandom; m_error = $urandom_range(0, 1);
      end
      m_gnt = ($urandom_range(0, 2) != 0);
      acc = m_req && m_gnt;
      if (i_ack) i_req = 0;
      else if (i_req) begin if ($urandom_range(0, 49) == 0) i_req = 0; end
      else if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
      if (d_ack) d_req = 0;
      else if (d_req) begin if ($urandom_range(0, 49) == 0) d_req = 0; end
      else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = $urandom; d_wen = $urandom_range(0, 1);
        d_strb = 4'($urandom); d_wdata = $urandom;
      end
      if ($urandom_range(0, 299) == 0) resetn = 0;
    end
    quiet(); resetn = 1;
    tick(); tick(); tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
